// File: rtl/fetch_stage_pkg.sv
// Shared hart definitions used by the fetch stage: NOP encoding, fetch FSM states
// and the F/D pipeline bundle.
package fetch_stage_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
   } fd_bundle_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with the next-PC priority mux:
// reset > redirect > hold > +4.
module fetch_pc
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_hold,
   output logic [XLEN-1:0] o_pc,
   output logic            o_misaligned
);

   logic [XLEN-1:0] pc_q, pc_d;

   // A misaligned target never reaches the PC; the stage halts instead.
   assign o_misaligned = i_redirect & (i_redirect_pc[1:0] != 2'b00);

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (i_redirect) begin
         pc_d = o_misaligned ? pc_q : i_redirect_pc;
      end else if (i_hold) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) pc_q <= RESET_ADDR;
      else          pc_q <= pc_d;
   end

   assign o_pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem read port and loads the
// F/D register; handles stall, redirect and halt.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic [XLEN-1:0] o_imem_raddr,
   input  logic [XLEN-1:0] i_imem_rdata,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_halt,
   output logic            o_fd_valid,
   output logic [XLEN-1:0] o_fd_inst,
   output logic [XLEN-1:0] o_fd_pc,
   output logic [XLEN-1:0] o_fd_pc4,
   output logic            o_halted
);

   fetch_state_e    state_q;
   fd_bundle_t      fd_q;
   logic            halted_q;
   logic [XLEN-1:0] pc;
   logic            misaligned;
   logic            pc_hold;

   assign pc_hold = i_halt | i_stall | (state_q == ST_HALTED);

   fetch_pc #(.RESET_ADDR(RESET_ADDR)) u_pc (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_hold        (pc_hold),
      .o_pc          (pc),
      .o_misaligned  (misaligned)
   );

   // A redirect comes from an older instruction, so it overrides halt/stall
   // and also pulls the stage out of HALTED.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= ST_RUN;
         halted_q <= 1'b0;
         fd_q     <= '{valid: 1'b0, inst: NOP_INST, pc: '0, pc4: '0};
      end else if (i_redirect) begin
         fd_q.valid <= 1'b0;
         state_q    <= misaligned ? ST_HALTED : ST_RUN;
         halted_q   <= misaligned;
      end else if (i_halt) begin
         fd_q.valid <= 1'b0;
         state_q    <= ST_HALTED;
         halted_q   <= 1'b1;
      end else if (state_q == ST_HALTED) begin
         fd_q.valid <= 1'b0;
      end else if (!i_stall) begin
         fd_q <= '{valid: 1'b1, inst: i_imem_rdata, pc: pc, pc4: pc + 32'd4};
      end
   end

   assign o_imem_raddr = pc;
   assign o_fd_valid   = fd_q.valid;
   assign o_fd_inst    = fd_q.inst;
   assign o_fd_pc      = fd_q.pc;
   assign o_fd_pc4     = fd_q.pc4;
   assign o_halted     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect, misaligned
// halt and recovery, PC wrap and reset mid-stall.
module tb_fetch_stage;

   localparam logic [31:0] PAT = 32'hA5A5_A5A5;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] raddr, rdata;
   logic        stall, redirect, halt;
   logic [31:0] redirect_pc;
   logic        fd_valid, halted;
   logic [31:0] fd_inst, fd_pc, fd_pc4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Memory model: instruction word is the address scrambled with a pattern.
   assign rdata = raddr ^ PAT;

   fetch_stage #(.RESET_ADDR(32'h0000_0000)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .o_imem_raddr  (raddr),
      .i_imem_rdata  (rdata),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .i_halt        (halt),
      .o_fd_valid    (fd_valid),
      .o_fd_inst     (fd_inst),
      .o_fd_pc       (fd_pc),
      .o_fd_pc4      (fd_pc4),
      .o_halted      (halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_fd(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, {31'd0, fd_valid}, 32'd1);
      chk({tag, "_pc"},    fd_pc,   pc);
      chk({tag, "_inst"},  fd_inst, pc ^ PAT);
      chk({tag, "_pc4"},   fd_pc4,  pc + 32'd4);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
      step(); step();
      chk("rst_valid", {31'd0, fd_valid}, 32'd0);
      chk("rst_inst",  fd_inst, NOP);
      chk("rst_pc",    fd_pc,   32'd0);
      chk("rst_pc4",   fd_pc4,  32'd0);
      chk("rst_raddr", raddr,   32'd0);
      chk("rst_halt",  {31'd0, halted}, 32'd0);

      // sequential fetch
      rst_n = 1'b1;
      step(); chk_fd("seq0", 32'd0); chk("seq0_raddr", raddr, 32'd4);
      step(); chk_fd("seq1", 32'd4);
      step(); chk_fd("seq2", 32'd8); chk("seq2_raddr", raddr, 32'd12);

      // stall for three cycles while holding pc 8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_fd("stall", 32'd8); chk("stall_raddr", raddr, 32'd12);
      end
      stall = 1'b0;
      step(); chk_fd("unstall", 32'd12); chk("unstall_raddr", raddr, 32'd16);

      // redirect together with stall: redirect wins
      redirect = 1'b1; redirect_pc = 32'h100; stall = 1'b1;
      step();
      redirect = 1'b0; stall = 1'b0;
      chk("rdst_valid", {31'd0, fd_valid}, 32'd0);
      chk("rdst_raddr", raddr, 32'h100);
      step(); chk_fd("rdst_tgt", 32'h100); chk("rdst_raddr2", raddr, 32'h104);

      // misaligned redirect halts without moving the PC
      redirect = 1'b1; redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
      chk("mis_halt",  {31'd0, halted},   32'd1);
      chk("mis_valid", {31'd0, fd_valid}, 32'd0);
      chk("mis_raddr", raddr, 32'h104);
      stall = 1'b1;
      step();
      stall = 1'b0;
      chk("mis_hold_halt",  {31'd0, halted},   32'd1);
      chk("mis_hold_valid", {31'd0, fd_valid}, 32'd0);
      chk("mis_hold_raddr", raddr, 32'h104);

      // halt then redirect (halt still high) to 0x40 recovers
      halt = 1'b1;
      step();
      chk("h_halt",  {31'd0, halted}, 32'd1);
      chk("h_raddr", raddr, 32'h104);
      redirect = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0; halt = 1'b0;
      chk("rec_halt",  {31'd0, halted},   32'd0);
      chk("rec_valid", {31'd0, fd_valid}, 32'd0);
      chk("rec_raddr", raddr, 32'h40);
      step(); chk_fd("rec_tgt", 32'h40); chk("rec_raddr2", raddr, 32'h44);

      // halt from RUN holds pc
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("run_halt",  {31'd0, halted},   32'd1);
      chk("run_valid", {31'd0, fd_valid}, 32'd0);
      chk("run_raddr", raddr, 32'h44);
      step();
      chk("run_halt2", {31'd0, halted}, 32'd1);
      chk("run_raddr2", raddr, 32'h44);

      // redirect to top of address space; PC wraps to 0
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      chk("wr_halt",  {31'd0, halted}, 32'd0);
      chk("wr_raddr", raddr, 32'hFFFF_FFFC);
      step();
      chk_fd("wr_top", 32'hFFFF_FFFC);
      chk("wr_pc4_zero", fd_pc4, 32'd0);
      chk("wr_raddr0",   raddr,  32'd0);
      step(); chk_fd("wr_zero", 32'd0);

      // reset during a stall
      stall = 1'b1;
      step(); chk_fd("pre_rst", 32'd0);
      rst_n = 1'b0;
      step();
      chk("rs_valid", {31'd0, fd_valid}, 32'd0);
      chk("rs_inst",  fd_inst, NOP);
      chk("rs_raddr", raddr,   32'd0);
      chk("rs_pc4",   fd_pc4,  32'd0);
      stall = 1'b0; rst_n = 1'b1;
      step(); chk_fd("rs_resume", 32'd0);

      // reset while HALTED
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("hr_halt", {31'd0, halted}, 32'd1);
      rst_n = 1'b0;
      step();
      chk("hr_halt0",  {31'd0, halted},   32'd0);
      chk("hr_valid",  {31'd0, fd_valid}, 32'd0);
      chk("hr_inst",   fd_inst, NOP);
      chk("hr_raddr",  raddr,   32'd0);
      rst_n = 1'b1;
      step(); chk_fd("hr_resume", 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined WISC-25 hart. It owns the program counter, drives the combinational instruction-memory read port, and loads the F/D pipeline register consumed by decode. It handles three control inputs: stalls from decode, redirects (taken branch/jump) from the memory stage, and halt requests (ebreak decoded).

## Interface
Parameters:
- RESET_ADDR, 32'h00000000, PC value loaded on reset.

Ports:
- i_clk  in  1  global clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous and active-low.
- o_imem_raddr  out  32  fetch address; always equals the PC register; always word-aligned.
- i_imem_rdata  in  32  instruction word, valid in the same cycle.
- i_stall  in  1  hold the PC and F/D register (decode hazard).
- i_redirect  in  1  taken branch/jump resolved in the memory stage; flush.
- i_redirect_pc  in  32  redirect target.
- i_halt  in  1  decode holds a valid ebreak; stop fetching.
- o_fd_valid  out  1  F/D register holds a real instruction.
- o_fd_inst  out  32  fetched instruction word, unmodified.
- o_fd_pc  out  32  address it was fetched from.
- o_fd_pc4  out  32  o_fd_pc + 4, mod 2^32.
- o_halted  out  1  block is in the HALTED state.

## Operation
- State machine has two states, RUN and HALTED. Reset enters RUN.
- Per-edge priority, highest first: reset, redirect, halt, stall, normal.
- Reset (i_rst_n=0):
  - pc <= RESET_ADDR, state <= RUN, o_fd_valid <= 0.
  - o_fd_inst <= 32'h00000013 (nop), o_fd_pc <= 0, o_fd_pc4 <= 0.
- Redirect, aligned target (i_redirect_pc[1:0]==0):
  - pc <= i_redirect_pc, o_fd_valid <= 0, state <= RUN.
  - This overrides stall and halt, because a halt seen in decode is on the wrong path when an older instruction redirects. HALTED is also left on redirect.
- Redirect, misaligned target: o_fd_valid <= 0, pc holds, state <= HALTED. The trap is retired by the branch itself; no further fetches.
- Halt, no redirect: state <= HALTED, o_fd_valid <= 0, pc holds.
- HALTED, no redirect: pc and F/D hold, o_fd_valid stays 0. Stall is ignored.
- Stall, RUN, no redirect or halt: pc and all o_fd_* hold their values, including o_fd_valid.
- Normal, RUN:
  - o_fd_inst <= i_imem_rdata, o_fd_pc <= pc, o_fd_pc4 <= pc+4, o_fd_valid <= 1.
  - pc <= pc+4. PC arithmetic wraps at 2^32: 0xFFFFFFFC -> 0x00000000.
- o_imem_raddr = pc combinationally. o_halted = (state==HALTED), registered.

## Timing
- Fetch-to-decode latency is 1 cycle: the word at pc in cycle N appears on o_fd_* in cycle N+1.
- First valid instruction after reset release: o_fd_valid=1, o_fd_pc=RESET_ADDR one edge after the first cycle with i_rst_n=1.
- Redirect penalty: the redirect edge produces one bubble. The target word is visible on o_fd_* one edge later.
- Throughput: one instruction per cycle when not stalled.
- Simultaneous redirect and stall: the redirect wins; the stalled F/D content is dropped.
- Reset asserted mid-stall or while HALTED: the reset values are restored on that edge.

## Structure
- Shared hart package holds:
  - the NOP word constant 32'h00000013;
  - the two-state encoding (RUN, HALTED);
  - the F/D bundle field widths.
- One sub-module, fetch_pc: PC register plus the next-PC priority mux (reset/redirect/hold/+4). It outputs pc and a misaligned-redirect flag. fetch_stage wraps it with the F/D register and the state machine.

## Test plan
- Sequential fetch: release reset with RESET_ADDR=0 and memory returning addr^0xA5A5A5A5. Required: o_fd_pc goes 0,4,8,12 with matching o_fd_inst, o_fd_pc4 = pc+4, and o_fd_valid=1 from cycle 1.
- Stall: assert i_stall for 3 cycles while o_fd_pc=8. Required: o_fd_* frozen at pc 8 and o_imem_raddr frozen at 12. The cycle after release shows o_fd_pc=12.
- Redirect with stall: i_redirect=1, i_redirect_pc=0x100, i_stall=1 in the same cycle. Required: next cycle o_fd_valid=0 and o_imem_raddr=0x100; the cycle after, o_fd_pc=0x100 with valid=1.
- Misaligned redirect and halt recovery:
  - i_redirect_pc=0x102. Required: o_halted=1, o_fd_valid stays 0, no PC change.
  - Then i_halt=1 followed by i_redirect to 0x40. Required: HALTED exits and the fetch resumes at 0x40.
- Wrap and reset mid-operation:
  - Redirect to 0xFFFFFFFC. Required: the next fetch address is 0x00000000, and o_fd_pc4=0 for that instruction.
  - Pulse i_rst_n=0 during a stall. Required: o_fd_valid=0, o_fd_inst=0x00000013, and o_imem_raddr=RESET_ADDR.
